// File: rtl/mips_pkg.sv
// Shared MIPS register-destination definitions: register indices, select
// encodings and the {valid, reg} pipeline entry used by dest_sel_pipe.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    DSEL_RT = 2'd0,
    DSEL_RD = 2'd1,
    DSEL_RA = 2'd2
  } dsel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } dest_entry_t;

endpackage

// File: rtl/dest_sel_pipe_if.sv
// Bundle of the destination-select pipeline's data/control and observation
// signals; master is the decode side, slave is dest_sel_pipe.
interface dest_sel_pipe_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_W,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DEPTH  = 3
);

  logic                    in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    stall;
  logic                    flush;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [DEPTH-1:0]        stage_valid;
  logic [DEPTH*WIDTH-1:0]  stage_data;

  modport master (
    output in_valid, in_data, sel, stall, flush,
    input  out_valid, out_data, stage_valid, stage_data
  );

  modport slave (
    input  in_valid, in_data, sel, stall, flush,
    output out_valid, out_data, stage_valid, stage_data
  );

endinterface

// File: rtl/dest_pipe_stage.sv
// One {valid, data} pipeline register with rst > flush > stall > load priority.
module dest_pipe_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           stall_i,
  input  logic [WIDTH:0] d_i,
  output logic [WIDTH:0] q_o
);

  logic [WIDTH:0] entry_q;
  logic [WIDTH:0] entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d = '0;
    end else if (!stall_i) begin
      entry_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/dest_sel_pipe.sv
// NUM_IN:1 destination-register select feeding a DEPTH-stage valid-tagged
// pipeline. Optional build macro: DEST_ZERO_SUPPRESS_EN.
module dest_sel_pipe
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_W,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DEPTH  = 3
) (
  input  logic            clk,
  input  logic            rst,
  dest_sel_pipe_if.slave  bus
);

  logic [WIDTH-1:0]       mux;
  logic                   cap_valid;
  logic [WIDTH:0]         stage_q [DEPTH];
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;

  // Out-of-range selects fall through to zero; valid is left alone here.
  always_comb begin
    mux = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        mux = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    cap_valid = bus.in_valid;
`ifdef DEST_ZERO_SUPPRESS_EN
    if (mux == '0) begin
      cap_valid = 1'b0;
    end
`endif
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH:0] stage_d;

    if (i == 0) begin : g_head
      assign stage_d = {cap_valid, mux};
    end else begin : g_body
      assign stage_d = stage_q[i-1];
    end

    dest_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.flush),
      .stall_i (bus.stall),
      .d_i     (stage_d),
      .q_o     (stage_q[i])
    );
  end

  always_comb begin
    stage_valid = '0;
    stage_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      stage_valid[i]              = stage_q[i][WIDTH];
      stage_data[i*WIDTH +: WIDTH] = stage_q[i][WIDTH-1:0];
    end
  end

  assign bus.stage_valid = stage_valid;
  assign bus.stage_data  = stage_data;
  assign bus.out_valid   = stage_q[DEPTH-1][WIDTH];
  assign bus.out_data    = stage_q[DEPTH-1][WIDTH-1:0];

endmodule
